// File: rtl/mips16_fetch_pkg.sv
// Shared types for the 16-bit MIPS instruction fetch front-end.
package mips16_fetch_pkg;

  localparam int unsigned PC_W    = 13;
  localparam int unsigned INSTR_W = 16;

  // FETCH: requests may issue; DRAIN: discarding stale responses after a redirect
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH-entry synchronous FIFO of {pc, instr} entries with
// occupancy count, simultaneous push/pop and a synchronous clear.
module fetch_fifo
  import mips16_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  fetch_entry_t            din,
  output fetch_entry_t            dout,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify push/pop against occupancy; a push into a full FIFO is legal only alongside a pop
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy tracking; clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only visible behind count
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, credit-limited imem
// requests, prefetch FIFO towards decode, redirect flush with response discard.
// Optional build macro FETCH_STATS_EN adds flush/stall statistics counters.
module instr_fetch_unit
  import mips16_fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_flush_cnt,
  output logic [15:0]        stat_stall_cnt
`endif
);

  localparam int unsigned     CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW:0]     DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   ONE_C     = CW'(1);
  localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0] resp_pc, resp_pc_nxt;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   discard, discard_nxt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit;
  logic            accept, rsp, push, pop;
  fetch_entry_t    fifo_din, fifo_head;

  // Request gating (credit rule keeps FIFO from overflowing) and next-state bookkeeping
  always_comb begin
    credit    = {1'b0, fifo_count} + {1'b0, outstanding};
    imem_addr = fetch_pc;
    imem_req  = rst && (state == FETCH) && !halt && !redirect_valid &&
                (outstanding < MAX_OUT_C) && (credit < DEPTH_C);
    accept    = imem_req && imem_gnt;
    // Responses with nothing outstanding belong to requests lost at reset
    rsp       = imem_rvalid && (outstanding != '0);
    push      = rsp && (discard == '0) && !redirect_valid;
    pop       = instr_valid && instr_ready;
    fifo_din  = '{pc: resp_pc, instr: imem_rdata};

    outstanding_nxt = outstanding;
    if (accept && !rsp)      outstanding_nxt = outstanding + ONE_C;
    else if (!accept && rsp) outstanding_nxt = outstanding - ONE_C;

    // On redirect accept is already blocked, so outstanding_nxt is exactly what is still in flight
    discard_nxt = discard;
    if (redirect_valid)              discard_nxt = outstanding_nxt;
    else if (rsp && discard != '0)   discard_nxt = discard - ONE_C;

    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) fetch_pc_nxt = redirect_pc;
    else if (accept)    fetch_pc_nxt = fetch_pc + PC_ONE;

    resp_pc_nxt = resp_pc;
    if (redirect_valid) resp_pc_nxt = redirect_pc;
    else if (push)      resp_pc_nxt = resp_pc + PC_ONE;
  end

  // Next-state logic for fetch/drain control
  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = (discard_nxt != '0) ? DRAIN : FETCH;
    else if (state == DRAIN && discard_nxt == '0)
      state_nxt = FETCH;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // PC, outstanding and discard counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  // Decode-side view of the FIFO head; idle values when empty
  always_comb begin
    instr_valid = (fifo_count != '0);
    instr_data  = instr_valid ? fifo_head.instr : '0;
    instr_pc    = instr_valid ? fifo_head.pc    : RESET_PC;
  end

`ifdef FETCH_STATS_EN
  // Saturating redirect and decode-starvation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_flush_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (redirect_valid && stat_flush_cnt != '1)
        stat_flush_cnt <= stat_flush_cnt + 16'd1;
      if (!instr_valid && !halt && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem model with programmable latency, an
// expected-PC scoreboard consumed by a decode-side monitor, directed phases.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [12:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [12:0] redirect_pc;
  logic        halt;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_flush_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  instr_fetch_unit #(
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (13'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef FETCH_STATS_EN
    ,
    .stat_flush_cnt (stat_flush_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [12:0] addr;
  } pend_t;

  pend_t       pend[$];
  pend_t       p;
  logic [12:0] exp_q[$];
  logic [12:0] e;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned hs = 0;
  int unsigned h0 = 0;
  int unsigned nredir = 0;

  function automatic logic [15:0] mem_word(input logic [12:0] a);
    return {a[4:0], a[12:2]} ^ 16'hC35A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [12:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(first + 13'(i));
  endtask

  task automatic drain_and_stop(input string name);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;
  endtask

  // imem model: record accepted requests, answer in order after lat cycles
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_req === 1'b1 && imem_gnt === 1'b1)
      pend.push_back('{due: cyc + lat, addr: imem_addr});
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(p.addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Decode-side monitor: every consumed instruction must match the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect_valid === 1'b0) begin
      hs++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc 0x%0h expected none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", 32'(instr_pc), 32'(e));
        chk("instr_data", 32'(instr_data), 32'(mem_word(e)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_gnt       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", 32'(instr_data), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_flush_cnt", 32'(stat_flush_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stat_stall_cnt), 32'd0);
`endif

    // Sequential stream, latency 1, decode always ready
    push_exp(13'd0, 10);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("fill_valid_0", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("fill_valid_1", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("first_valid", 32'(instr_valid), 32'd1);
    repeat (8) begin
      tick();
      @(negedge clk);
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_req", 32'(imem_req), 32'd1);
    end
    tick();
    drain_and_stop("drain_stream");

    // Decode back-pressure: head holds, FIFO fills to DEPTH, requests stop
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_head_pc", 32'(instr_pc), 32'd10);
      if (i == 9) begin
        chk("stall_head_data", 32'(instr_data), 32'(mem_word(13'd10)));
        chk("stall_req_off", 32'(imem_req), 32'd0);
        chk("stall_outstanding", 32'(pend.size()), 32'd0);
      end
      tick();
    end
    push_exp(13'd10, 5);
    instr_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("release_no_gap", 32'(instr_valid), 32'd1);
      tick();
    end
    drain_and_stop("drain_release");

    // Redirect with two outstanding at latency 3
    repeat (8) tick();
    chk("quiesce_a", 32'(pend.size()), 32'd0);
    lat = 3;
    push_exp(13'h100, 4);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 13'h050;
    nredir++;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush_a", 32'(instr_valid), 32'd0);
    tick();
    tick();
    chk("max_out_block", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 13'h100;
    nredir++;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush_b", 32'(instr_valid), 32'd0);
    drain_and_stop("drain_redirect");

    // PC wrap 8190 -> 8191 -> 0 -> 1
    repeat (12) tick();
    chk("quiesce_b", 32'(pend.size()), 32'd0);
    lat = 1;
    push_exp(13'd8190, 4);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 13'd8190;
    nredir++;
    tick();
    redirect_valid = 1'b0;
    drain_and_stop("drain_wrap");

    // Redirect coinciding with a response and a decode pop
    repeat (12) tick();
    chk("quiesce_c", 32'(pend.size()), 32'd0);
    lat = 2;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 13'h200;
    nredir++;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_coll_valid", 32'(instr_valid), 32'd1);
    chk("pre_coll_pc", 32'(instr_pc), 32'h200);
    push_exp(13'h300, 12);
    redirect_valid = 1'b1;
    redirect_pc    = 13'h300;
    instr_ready    = 1'b1;
    nredir++;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("coll_flush", 32'(instr_valid), 32'd0);

    // halt mid-run: no new requests, in-flight still reaches decode
    repeat (6) tick();
    halt = 1'b1;
    h0   = hs;
    repeat (5) begin
      @(negedge clk);
      chk("halt_req_off", 32'(imem_req), 32'd0);
      tick();
    end
    chk("halt_delivers", 32'(hs != h0), 32'd1);
    halt = 1'b0;
    drain_and_stop("drain_halt");

`ifdef FETCH_STATS_EN
    chk("flush_cnt", 32'(stat_flush_cnt), 32'(nredir));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
